// File: rtl/agc_gain_ctrl.sv
// AGC loop controller: windowed mean magnitude, hysteresis compare, saturating gain stepping and lock.
// Optional AGC_LOCK_FREEZE_EN: a lock-breaking UP/DOWN decision leaves the gain unchanged for that evaluation.
//
// state    | meaning
// S_ACCUM  | accumulate magnitudes of enabled samples until the window is full
// S_EVAL   | compare the window mean against the hysteresis band, register the decision
// S_UPDATE | apply the decision to gain and lock, pulse o_gain_valid, clear the window
module agc_gain_ctrl #(
   parameter int NB_INPUT  = 14,
   parameter int LOG2_WIN  = 6,
   parameter int NB_GAIN   = 6,
   parameter int GAIN_INIT = 32,
   parameter int TARGET    = 4096,
   parameter int HYST      = 256,
   parameter int LOCK_CNT  = 4
) (
   input  logic                       clk,
   input  logic                       i_srst,
   input  logic                       i_en,
   input  logic signed [NB_INPUT-1:0] i_is_data,
   output logic        [NB_GAIN-1:0]  o_gain,
   output logic                       o_gain_valid,
   output logic                       o_locked,
   output logic        [NB_INPUT-2:0] o_mean
);

   localparam int NB_MAG = NB_INPUT - 1;
   localparam int NB_ACC = NB_MAG + LOG2_WIN;
   localparam logic [NB_GAIN-1:0] GAIN_MAX  = '1;
   localparam logic [NB_GAIN-1:0] GAIN_RST  = NB_GAIN'(GAIN_INIT);
   localparam logic [NB_MAG-1:0]  THR_HI    = NB_MAG'(TARGET + HYST);
   localparam logic [NB_MAG-1:0]  THR_LO    = NB_MAG'(TARGET - HYST);
   localparam logic [3:0]         LOCK_TGT  = 4'(LOCK_CNT);

   typedef enum logic [1:0] {S_ACCUM, S_EVAL, S_UPDATE} state_t;
   typedef enum logic [1:0] {D_HOLD, D_UP, D_DOWN} dec_t;

   state_t              state_q, state_d;
   dec_t                dec_q, dec_d;
   logic [NB_ACC-1:0]   acc_q, acc_d, acc_sum;
   logic [LOG2_WIN-1:0] cnt_q, cnt_d;
   logic [NB_MAG-1:0]   mean_q, mean_d;
   logic [NB_GAIN-1:0]  gain_q, gain_d;
   logic [3:0]          lock_cnt_q, lock_cnt_d;
   logic                locked_q, locked_d;
   logic                gain_valid_q, gain_valid_d;
   logic [NB_INPUT-1:0] neg;
   logic [NB_MAG-1:0]   mag;
   logic                step_en;

   // Negating the most negative code yields itself; its set top bit flags saturation.
   always_comb begin
      neg = '0 - i_is_data;
      if (i_is_data[NB_INPUT-1]) begin
         mag = neg[NB_MAG] ? '1 : neg[NB_MAG-1:0];
      end else begin
         mag = i_is_data[NB_MAG-1:0];
      end
      acc_sum = acc_q + NB_ACC'(mag);
   end

`ifdef AGC_LOCK_FREEZE_EN
   assign step_en = !locked_q;
`else
   assign step_en = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      dec_d        = dec_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      mean_d       = mean_q;
      gain_d       = gain_q;
      lock_cnt_d   = lock_cnt_q;
      gain_valid_d = 1'b0;
      case (state_q)
         S_ACCUM: begin
            if (i_en) begin
               acc_d = acc_sum;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  mean_d  = acc_sum[NB_ACC-1:LOG2_WIN];
                  state_d = S_EVAL;
               end
            end
         end
         S_EVAL: begin
            if (mean_q > THR_HI) begin
               dec_d = D_DOWN;
            end else if (mean_q < THR_LO) begin
               dec_d = D_UP;
            end else begin
               dec_d = D_HOLD;
            end
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            gain_valid_d = 1'b1;
            acc_d        = '0;
            cnt_d        = '0;
            state_d      = S_ACCUM;
            case (dec_q)
               D_UP: begin
                  lock_cnt_d = '0;
                  if (step_en && gain_q != GAIN_MAX) gain_d = gain_q + 1'b1;
               end
               D_DOWN: begin
                  lock_cnt_d = '0;
                  if (step_en && gain_q != '0) gain_d = gain_q - 1'b1;
               end
               default: begin
                  if (lock_cnt_q != LOCK_TGT) lock_cnt_d = lock_cnt_q + 1'b1;
               end
            endcase
         end
         default: state_d = S_ACCUM;
      endcase
      locked_d = (lock_cnt_d == LOCK_TGT);
   end

   always_ff @(posedge clk) begin
      if (i_srst) begin
         state_q      <= S_ACCUM;
         dec_q        <= D_HOLD;
         acc_q        <= '0;
         cnt_q        <= '0;
         mean_q       <= '0;
         gain_q       <= GAIN_RST;
         lock_cnt_q   <= '0;
         locked_q     <= 1'b0;
         gain_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dec_q        <= dec_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         mean_q       <= mean_d;
         gain_q       <= gain_d;
         lock_cnt_q   <= lock_cnt_d;
         locked_q     <= locked_d;
         gain_valid_q <= gain_valid_d;
      end
   end

   assign o_gain       = gain_q;
   assign o_gain_valid = gain_valid_q;
   assign o_locked     = locked_q;
   assign o_mean       = mean_q;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Directed bench for agc_gain_ctrl; expected values are hand-derived from the default parameters.
module tb_agc_gain_ctrl;

   logic               clk = 1'b0;
   logic               i_srst = 1'b1;
   logic               i_en = 1'b0;
   logic signed [13:0] i_is_data = '0;
   logic        [5:0]  o_gain;
   logic               o_gain_valid;
   logic               o_locked;
   logic        [12:0] o_mean;

   int tests = 0;
   int fails = 0;

   agc_gain_ctrl dut (
      .clk          (clk),
      .i_srst       (i_srst),
      .i_en         (i_en),
      .i_is_data    (i_is_data),
      .o_gain       (o_gain),
      .o_gain_valid (o_gain_valid),
      .o_locked     (o_locked),
      .o_mean       (o_mean)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input bit en, input int d);
      i_en      = en;
      i_is_data = 14'(d);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_srst = 1'b1;
      step(1'b1, 8000);
      step(1'b1, 8000);
      i_srst = 1'b0;
   endtask

   // 64 consecutive enabled samples; alt negates odd-indexed samples.
   task automatic run_window(input int v, input bit alt, input int exp_mean, input string tag);
      for (int i = 0; i < 64; i++) step(1'b1, (alt && i[0]) ? -v : v);
      check({tag, "_mean"}, o_mean, exp_mean);
   endtask

   // Steps through S_EVAL and S_UPDATE, then checks the evaluation result.
   task automatic finish_eval(input bit en, input int d, input int exp_gain, input int exp_lock,
                              input string tag);
      step(en, d);
      check({tag, "_valid_early"}, o_gain_valid, 0);
      step(en, d);
      check({tag, "_valid"}, o_gain_valid, 1);
      check({tag, "_gain"}, o_gain, exp_gain);
      check({tag, "_locked"}, o_locked, exp_lock);
   endtask

   initial begin
      int g;
      int exp_g;

      // Reset with enable and data active
      do_reset();
      check("rst_gain", o_gain, 32);
      check("rst_locked", o_locked, 0);
      check("rst_valid", o_gain_valid, 0);
      check("rst_mean", o_mean, 0);

      // +8000: above band, one DOWN step, single pulse
      run_window(8000, 1'b0, 8000, "pos8000");
      check("pos8000_gain_before", o_gain, 32);
      finish_eval(1'b0, 0, 31, 0, "pos8000");
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 0);
         check("pos8000_single_pulse", o_gain_valid, 0);
      end

      // -8192 saturates to 8191
      do_reset();
      run_window(-8192, 1'b0, 8191, "neg8192");
      finish_eval(1'b0, 0, 31, 0, "neg8192");

      // +/-4096 in band: hold and build lock
      do_reset();
      for (int w = 1; w <= 4; w++) begin
         run_window(4096, 1'b1, 4096, "alt4096");
         finish_eval(1'b0, 0, 32, (w == 4) ? 1 : 0, "alt4096");
      end
`ifdef AGC_LOCK_FREEZE_EN
      run_window(0, 1'b0, 0, "unlock0");
      finish_eval(1'b0, 0, 32, 0, "unlock0");
      run_window(0, 1'b0, 0, "resume0");
      finish_eval(1'b0, 0, 33, 0, "resume0");
`else
      run_window(0, 1'b0, 0, "unlock0");
      finish_eval(1'b0, 0, 33, 0, "unlock0");
      run_window(0, 1'b0, 0, "resume0");
      finish_eval(1'b0, 0, 34, 0, "resume0");
`endif

      // Zero input: UP saturation at 63
      do_reset();
      g = 32;
      for (int w = 1; w <= 40; w++) begin
         g = (g < 63) ? g + 1 : 63;
         run_window(0, 1'b0, 0, "zero");
         finish_eval(1'b0, 0, g, 0, "zero");
      end
      check("zero_sat_final", o_gain, 63);

      // Large input: DOWN saturation at 0
      for (int w = 1; w <= 65; w++) begin
         g = (g > 0) ? g - 1 : 0;
         run_window(8000, 1'b0, 8000, "big");
         finish_eval(1'b0, 0, g, 0, "big");
      end
      check("big_sat_final", o_gain, 0);

      // Truncated mean: 127/64 -> 1
      do_reset();
      for (int i = 0; i < 63; i++) step(1'b1, 0);
      step(1'b1, 127);
      check("trunc_mean", o_mean, 1);
      finish_eval(1'b0, 0, 33, 0, "trunc");

      // Reset after 30 samples with i_en toggling; dropped samples in EVAL/UPDATE
      do_reset();
      for (int i = 0; i < 30; i++) begin
         step(1'b1, 8000);
         step(1'b0, 8000);
      end
      i_srst = 1'b1;
      step(1'b1, 8000);
      i_srst = 1'b0;
      check("midrst_mean", o_mean, 0);
      check("midrst_gain", o_gain, 32);
      for (int i = 0; i < 64; i++) begin
         step(1'b1, 1000);
         if (i < 63) step(1'b0, 5000);
      end
      check("toggle_mean", o_mean, 1000);
      exp_g = 33;
      finish_eval(1'b1, 8191, exp_g, 0, "toggle");
      check("toggle_mean_hold", o_mean, 1000);
      run_window(2000, 1'b0, 2000, "after_drop");
      finish_eval(1'b0, 0, 34, 0, "after_drop");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/agc_gain_ctrl.md
# agc_gain_ctrl

Automatic-gain-control loop controller sitting directly downstream of the lowpass FIR stage. It consumes the filtered signed samples and measures their mean magnitude over a fixed power-of-two window. It compares that mean against a target with hysteresis and steps an unsigned gain code up or down for the upstream variable-gain stage. It also reports a lock flag once the level has stayed in-window for a configurable number of consecutive evaluations.

## Interface
- NB_INPUT, 14, width of the signed input sample (integer format, matches filter output)
- LOG2_WIN, 6, log2 of the averaging window length in enabled samples (default 64)
- NB_GAIN, 6, width of the unsigned gain code; GAIN_MAX = 2^NB_GAIN-1
- GAIN_INIT, 32, gain code loaded at reset
- TARGET, 4096, target mean magnitude (unsigned, NB_INPUT-1 bits)
- HYST, 256, half-width of the in-window band; TARGET±HYST must stay inside [0, 2^(NB_INPUT-1)-1]
- LOCK_CNT, 4, consecutive in-window evaluations required to assert lock (1..15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- i_srst  in  1  synchronous reset, active-high, overrides every other input
- i_en  in  1  sample valid/enable; one sample accepted per cycle with i_en=1
- i_is_data  in  NB_INPUT  signed filtered sample
- o_gain  out  NB_GAIN  current gain code; reset value GAIN_INIT
- o_gain_valid  out  1  one-cycle pulse per evaluation; reset value 0
- o_locked  out  1  level-in-window lock flag; reset value 0
- o_mean  out  NB_INPUT-1  last completed window mean magnitude; reset value 0

## Operation
- Magnitude: |x| in NB_INPUT-1 bits unsigned; most negative input -2^(NB_INPUT-1) saturates to 2^(NB_INPUT-1)-1.
- Accumulator: NB_INPUT-1+LOG2_WIN bits, cannot overflow. Mean = acc >> LOG2_WIN, truncated.
- FSM with three states:
  - S_ACCUM: each cycle with i_en=1 adds the magnitude and increments the sample counter. On the 2^LOG2_WIN-th accepted sample, write the mean of the full window (including that sample) to o_mean, then go to S_EVAL.
  - S_EVAL (1 cycle): register the decision. DOWN if mean > TARGET+HYST, UP if mean < TARGET-HYST, else HOLD. Go to S_UPDATE.
  - S_UPDATE (1 cycle): apply the decision, pulse o_gain_valid, update lock, clear accumulator and counter. Go to S_ACCUM.
- Gain step is ±1 with saturation: DOWN at 0 stays 0; UP at GAIN_MAX stays GAIN_MAX.
- Lock counter:
  - HOLD increments it, saturating at LOCK_CNT.
  - UP or DOWN clears it to 0.
  - o_locked = (counter == LOCK_CNT), registered at the same edge.
- Samples presented with i_en=1 while in S_EVAL or S_UPDATE are dropped; they are not carried into the next window.
- i_en=0 freezes accumulation only. An evaluation already in progress completes regardless of i_en.
- Reset mid-window discards the partial window. All state returns to reset values: S_ACCUM, acc=0, count=0, lock counter 0.

## Timing
- Edge k accepts the last sample of a window; o_mean is new after edge k.
- Edge k+1: decision registered.
- Edge k+2: o_gain, o_locked and lock counter update. o_gain_valid is high for exactly the cycle after edge k+2.
- First sample of the next window can be accepted at edge k+3.
- Minimum evaluation period: 2^LOG2_WIN+2 cycles.
- i_srst asserted at any edge forces all outputs to their reset values after that edge.

## Configuration
- AGC_LOCK_FREEZE_EN:
  - Defined: while o_locked=1, an UP/DOWN decision clears lock but leaves o_gain unchanged for that evaluation. Gain stepping resumes from the next evaluation. o_gain_valid still pulses.
  - Not defined: gain steps on every UP/DOWN decision regardless of lock.

## Test plan
- Reset: assert i_srst 2 cycles with i_en=1 and data 8000 -> o_gain=32, o_locked=0, o_gain_valid=0, o_mean=0.
- Constant +8000 for 64 enabled samples -> o_mean=8000; o_gain=31 and o_gain_valid pulse 2 cycles after the last sample; exactly one pulse.
- Constant -8192 for 64 samples -> o_mean=8191 (saturated magnitude); o_gain 32->31.
- Alternating +4096/-4096 for 4 windows -> o_gain stays 32. o_locked rises at the 4th UPDATE. A following window of 0s clears o_locked; o_gain 32->33, or stays 32 with AGC_LOCK_FREEZE_EN.
- Constant 0 for 40 windows -> o_gain increments once per window, saturates at 63 after window 31, stays 63.
- i_en toggling 1/0 with reset at sample 30 of a window -> partial window discarded; next o_mean is computed from 64 post-reset samples only; samples offered during S_EVAL/S_UPDATE do not alter o_mean.
